// File: rtl/score_pulse_gen.sv
// Purpose : banks scoring events and drains them as spaced one-cycle score_inc pulses.
// Latency : event sampled at edge k while idle and empty -> score_inc high in cycle k+1.
// Backpressure: none upstream; the bank absorbs bursts and saturates at 2^CNT_W-1 (sticky overflow).
//
// Ports:
//   clk_i          system clock
//   resetn_i       asynchronous reset, active-low
//   clear_i        synchronous clear (new game), dominates all other inputs
//   event_valid_i  scoring event (pulse, or level when SCORE_EDGE_DET_EN is defined)
//   event_pts_i    points for this event, 0 = ignored
//   score_inc_o    one-cycle increment pulse, decoded straight from the state register
//   pending_o      points banked and not yet emitted
//   busy_o         state not idle or points still banked
//   overflow_o     sticky: the bank saturated since reset/clear
// Optional feature: define SCORE_EDGE_DET_EN to accept events only on a 0->1 edge of event_valid_i.
module score_pulse_gen #(
  parameter int PTS_W      = 3,
  parameter int CNT_W      = 6,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             clear_i,
  input  logic             event_valid_i,
  input  logic [PTS_W-1:0] event_pts_i,
  output logic             score_inc_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             busy_o,
  output logic             overflow_o
);

  localparam int GW = 8;
  localparam int SW = CNT_W + 1;
  localparam logic [SW-1:0] PEND_MAX = {1'b0, {CNT_W{1'b1}}};
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic [SW-1:0]    sum;
  logic             sat;
  logic             more;

`ifdef SCORE_EDGE_DET_EN
  // Previous level of event_valid_i; resets low so a level already high
  // when reset releases still counts as one event.
  logic ev_prev_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      ev_prev_q <= 1'b0;
    end else begin
      ev_prev_q <= event_valid_i;
    end
  end

  assign accept = event_valid_i & ~ev_prev_q & (event_pts_i != '0) & ~clear_i;
`else
  assign accept = event_valid_i & (event_pts_i != '0) & ~clear_i;
`endif

  // One bit wider than the bank so the clamp can see the carry. The bank is
  // never zero while in PULSE, so the decrement cannot underflow.
  always_comb begin
    sum = {1'b0, pending_q}
        + (accept ? SW'(event_pts_i) : '0)
        - ((state_q == PULSE) ? SW'(1) : '0);
    sat = (sum > PEND_MAX);
  end

  assign more = (pending_q != '0) || accept;

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    pending_d = sat ? PEND_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
    ovf_d     = ovf_q | sat;

    unique case (state_q)
      IDLE: begin
        if (more) state_d = PULSE;
      end
      PULSE: begin
        gap_d   = GAP_LOAD;
        state_d = GAP;
      end
      GAP: begin
        gap_d = gap_q - GW'(1);
        // gap_q == 1 marks the last idle cycle of the gap
        if (gap_q <= GW'(1)) begin
          state_d = more ? PULSE : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = '0;
      end
    endcase

    if (clear_i) begin
      state_d   = IDLE;
      gap_d     = '0;
      pending_d = '0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign score_inc_o = (state_q == PULSE);
  assign pending_o   = pending_q;
  assign busy_o      = (state_q != IDLE) || (pending_q != '0);
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_score_pulse_gen.sv
module tb_score_pulse_gen;

  localparam int PTS_W = 3;
  localparam int CNT_W = 6;
  localparam int GAP   = 2;
  localparam int MAXP  = (1 << CNT_W) - 1;

  logic             clk;
  logic             resetn;
  logic             clear;
  logic             ev_vld;
  logic [PTS_W-1:0] ev_pts;
  logic             score_inc;
  logic [CNT_W-1:0] pending;
  logic             busy;
  logic             overflow;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a bank of points plus a count of idle cycles still owed
  // after the most recent pulse.
  int m_pend;
  int m_cd;
  bit m_pulse;
  bit m_ovf;
  bit m_prev;
  int pulse_cnt;

  score_pulse_gen #(.PTS_W(PTS_W), .CNT_W(CNT_W), .GAP_CYCLES(GAP)) dut (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .clear_i      (clear),
    .event_valid_i(ev_vld),
    .event_pts_i  (ev_pts),
    .score_inc_o  (score_inc),
    .pending_o    (pending),
    .busy_o       (busy),
    .overflow_o   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = 0;
    m_cd    = 0;
    m_pulse = 0;
    m_ovf   = 0;
    m_prev  = 0;
  endtask

  task automatic model_edge(input bit v, input int p, input bit c);
    bit acc;
    int np;
`ifdef SCORE_EDGE_DET_EN
    acc = v && !m_prev && (p != 0) && !c;
`else
    acc = v && (p != 0) && !c;
`endif
    m_prev = v;
    if (c) begin
      m_pend  = 0;
      m_ovf   = 0;
      m_cd    = 0;
      m_pulse = 0;
    end else begin
      np = m_pend + (acc ? p : 0) - (m_pulse ? 1 : 0);
      if (np > MAXP) begin
        np    = MAXP;
        m_ovf = 1;
      end
      m_pend = np;
      if (m_pulse) begin
        m_pulse = 0;
        m_cd    = GAP;
      end else if (m_cd > 1) begin
        m_cd = m_cd - 1;
      end else begin
        m_cd    = 0;
        m_pulse = (np > 0);
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".score_inc"}, int'(score_inc), int'(m_pulse));
    chk({tag, ".pending"},   int'(pending),   m_pend);
    chk({tag, ".busy"},      int'(busy),      int'(m_pulse || m_cd > 0 || m_pend > 0));
    chk({tag, ".overflow"},  int'(overflow),  int'(m_ovf));
  endtask

  // Drive inputs for one cycle, let the edge happen, then compare 1 time unit later.
  task automatic step(input string tag, input bit v, input int p, input bit c);
    ev_vld = v;
    ev_pts = PTS_W'(p);
    clear  = c;
    @(posedge clk);
    model_edge(v, p, c);
    #1;
    if (score_inc) pulse_cnt++;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0);
  endtask

  initial begin
    resetn = 1'b0;
    clear  = 1'b0;
    ev_vld = 1'b0;
    ev_pts = '0;
    pulse_cnt = 0;
    model_reset();
    #12;
    chk("rst.score_inc", int'(score_inc), 0);
    chk("rst.pending",   int'(pending),   0);
    chk("rst.busy",      int'(busy),      0);
    chk("rst.overflow",  int'(overflow),  0);
    @(negedge clk);
    resetn = 1'b1;

    // Single 1-point event: pulse next cycle, idle again after the gap.
    step("t1", 1, 1, 0);
    chk("t1.pulse_c1", int'(score_inc), 1);
    chk("t1.pend_c1",  int'(pending),   1);
    idle("t1", 2);
    step("t1", 0, 0, 0);
    chk("t1.busy_c4", int'(busy), 0);

    // Three points drain as pulses three cycles apart.
    pulse_cnt = 0;
    step("t2", 1, 3, 0);
    idle("t2", 9);
    chk("t2.pulses", pulse_cnt, 3);

    // Burst of maximum-value events saturates the bank.
    for (int i = 0; i < 10; i++) step("t3", 1, 7, 0);
    chk("t3.pend_sat", int'(pending),  MAXP);
    chk("t3.ovf",      int'(overflow), 1);
    idle("t3", 4);
    chk("t3.ovf_sticky", int'(overflow), 1);
    step("t3clr", 0, 0, 1);
    chk("t3.clr_pend", int'(pending),  0);
    chk("t3.clr_ovf",  int'(overflow), 0);
    idle("t3", 4);

    // Event arriving in the same cycle as a pulse exit.
    step("t4", 1, 1, 0);
    step("t4", 1, 2, 0);
    chk("t4.pend", int'(pending), 2);
    idle("t4", 8);

    // Clear during a gap with points still banked.
    step("t5", 1, 5, 0);
    step("t5", 0, 0, 0);
    step("t5clr", 1, 3, 1);
    chk("t5.busy", int'(busy), 0);
    pulse_cnt = 0;
    idle("t5", 6);
    chk("t5.no_pulse", pulse_cnt, 0);

    // Zero-point event is ignored.
    step("zero", 1, 0, 0);
    idle("zero", 2);

    // Level held for five cycles.
    pulse_cnt = 0;
    for (int i = 0; i < 5; i++) step("hold", 1, 2, 0);
    idle("hold", 40);
`ifdef SCORE_EDGE_DET_EN
    chk("hold.edge_pulses", pulse_cnt, 2);
`else
    chk("hold.level_pulses", pulse_cnt, 10);
`endif

    // Asynchronous reset in the middle of a pulse.
    step("arst", 1, 4, 0);
    resetn = 1'b0;
    model_reset();
    #1;
    chk("arst.score_inc", int'(score_inc), 0);
    chk("arst.pending",   int'(pending),   0);
    chk("arst.busy",      int'(busy),      0);
    ev_vld = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    idle("arst", 2);

    // Randomized traffic with occasional clears and dense bursts.
    for (int i = 0; i < 600; i++) begin
      bit v;
      bit c;
      int p;
      if ((i / 100) % 2 == 1) v = ($urandom_range(0, 3) != 0);
      else                    v = ($urandom_range(0, 4) == 0);
      p = $urandom_range(0, 7);
      c = ($urandom_range(0, 59) == 0);
      step("rnd", v, p, c);
    end
    idle("drain", 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
